// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared opcode constants, instruction field slicing and register-use helpers
// for the execute-stage hazard controller.
package ex_hazard_ctrl_pkg;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_IJMP = 6'h02;
  localparam logic [5:0] OP_CDEC = 6'h0C;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  typedef enum logic {IDLE, FLUSH} hz_state_t;

  function automatic logic [5:0] op_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  // Non-writers report r0, which is never allowed to match a source.
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    case (op_of(ir))
      OP_ALU:          return rd_of(ir);
      OP_LW, OP_CDEC:  return rt_of(ir);
      default:         return 5'd0;
    endcase
  endfunction

  function automatic logic is_alu_wr(input logic [31:0] ir);
    return (op_of(ir) == OP_ALU) || (op_of(ir) == OP_CDEC);
  endfunction

  function automatic logic uses_a(input logic [31:0] ir);
    case (op_of(ir))
      OP_ALU, OP_LW, OP_SW, OP_CDEC, OP_IJMP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic uses_b(input logic [31:0] ir);
    case (op_of(ir))
      OP_ALU, OP_SW, OP_CDEC, OP_IJMP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_bypass.sv
// Combinational bypass-select generation for both execute operands.
// Index 0 of every vector is operand A (rs), index 1 is operand B (rt).
module ex_bypass_detect
  import ex_hazard_ctrl_pkg::*;
(
  input  logic        en,
  input  logic [31:0] idex_ir,
  input  logic [31:0] exmem_ir,
  input  logic [31:0] memwb_ir,
  output logic [1:0]  from_mem,
  output logic [1:0]  from_alu_wb,
  output logic [1:0]  from_lw_wb
);

  logic [1:0][4:0] src;
  logic [1:0]      used;
  logic [4:0]      mem_dst, wb_dst;

  assign src     = {rt_of(idex_ir), rs_of(idex_ir)};
  assign used    = {uses_b(idex_ir), uses_a(idex_ir)};
  assign mem_dst = dest_of(exmem_ir);
  assign wb_dst  = dest_of(memwb_ir);

  for (genvar k = 0; k < 2; k++) begin : g_opnd
    logic live, hit_mem;
    // A zero source can never be forwarded, so it also rules out r0 destinations.
    assign live    = en && used[k] && (src[k] != 5'd0);
    assign hit_mem = live && is_alu_wr(exmem_ir) && (mem_dst == src[k]);
    assign from_mem[k]    = hit_mem;
    assign from_alu_wb[k] = live && !hit_mem && is_alu_wr(memwb_ir) && (wb_dst == src[k]);
    assign from_lw_wb[k]  = live && !hit_mem && (op_of(memwb_ir) == OP_LW)
                            && (rt_of(memwb_ir) == src[k]);
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand bypass selects, one-cycle load-use
// stall, IJMP flush sequencing and saturating stall/flush event counters.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IFIDIR,
  input  logic [31:0]      IDEXIR,
  input  logic [31:0]      EXMEMIR,
  input  logic [31:0]      MEMWBIR,
  output logic             bypassAfromMEM,
  output logic             bypassAfromALUinWB,
  output logic             bypassAfromLWinWB,
  output logic             bypassBfromMEM,
  output logic             bypassBfromALUinWB,
  output logic             bypassBfromLWinWB,
  output logic             stall,
  output logic             ijmpMem,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] from_mem, from_alu_wb, from_lw_wb;

  ex_bypass_detect u_bypass (
    .en          (!reset),
    .idex_ir     (IDEXIR),
    .exmem_ir    (EXMEMIR),
    .memwb_ir    (MEMWBIR),
    .from_mem    (from_mem),
    .from_alu_wb (from_alu_wb),
    .from_lw_wb  (from_lw_wb)
  );

  assign bypassAfromMEM     = from_mem[0];
  assign bypassAfromALUinWB = from_alu_wb[0];
  assign bypassAfromLWinWB  = from_lw_wb[0];
  assign bypassBfromMEM     = from_mem[1];
  assign bypassBfromALUinWB = from_alu_wb[1];
  assign bypassBfromLWinWB  = from_lw_wb[1];

  logic [4:0] ld_rt;
  logic       load_use;

  assign ld_rt    = rt_of(IDEXIR);
  assign load_use = (op_of(IDEXIR) == OP_LW) && (ld_rt != 5'd0)
                    && ((ld_rt == rs_of(IFIDIR))
                        || (uses_b(IFIDIR) && (ld_rt == rt_of(IFIDIR))));

  // A flush kills the consumer anyway, so it wins over the load-use bubble.
  assign stall = !reset && load_use && !ijmpMem;

  hz_state_t  state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ijmpMem     = 1'b0;
    pc_redirect = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: if (op_of(EXMEMIR) == OP_IJMP) begin
          ijmpMem     = 1'b1;
          pc_redirect = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          // IJMPs arriving here sit in slots being flushed and are ignored.
          ijmpMem = 1'b1;
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))       stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of the
// hazard rules; a second narrow-counter instance exercises saturation.
module tb_ex_hazard_ctrl;
  import ex_hazard_ctrl_pkg::*;

  localparam int FC = 2;

  logic clk = 1'b0, reset;
  logic [31:0] ifid, idex, exmem, memwb;
  logic [31:0] ifid2, idex2, exmem2, memwb2;
  logic bam, baw, bal, bbm, bbw, bbl, stall, ijmp, redir;
  logic bam2, baw2, bal2, bbm2, bbw2, bbl2, stall2, ijmp2, redir2;
  logic [15:0] scnt, fcnt;
  logic [3:0]  scnt2, fcnt2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .IFIDIR(ifid), .IDEXIR(idex), .EXMEMIR(exmem), .MEMWBIR(memwb),
    .bypassAfromMEM(bam), .bypassAfromALUinWB(baw), .bypassAfromLWinWB(bal),
    .bypassBfromMEM(bbm), .bypassBfromALUinWB(bbw), .bypassBfromLWinWB(bbl),
    .stall(stall), .ijmpMem(ijmp), .pc_redirect(redir), .stall_cnt(scnt), .flush_cnt(fcnt));

  ex_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .IFIDIR(ifid2), .IDEXIR(idex2), .EXMEMIR(exmem2), .MEMWBIR(memwb2),
    .bypassAfromMEM(bam2), .bypassAfromALUinWB(baw2), .bypassAfromLWinWB(bal2),
    .bypassBfromMEM(bbm2), .bypassBfromALUinWB(bbw2), .bypassBfromLWinWB(bbl2),
    .stall(stall2), .ijmpMem(ijmp2), .pc_redirect(redir2), .stall_cnt(scnt2), .flush_cnt(fcnt2));

  wire [5:0] byp = {bam, baw, bal, bbm, bbw, bbl};

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  localparam logic [31:0] NOP = {OP_NOP, 26'd0};

  // Reference model: register number written by an instruction, 0 when none.
  function automatic int writes(input logic [31:0] ir);
    logic [5:0] op = ir[31:26];
    if (op == OP_ALU) return int'(ir[15:11]);
    if (op == OP_LW || op == OP_CDEC) return int'(ir[20:16]);
    return 0;
  endfunction

  function automatic bit alu_class(input logic [31:0] ir);
    logic [5:0] op = ir[31:26];
    return op == OP_ALU || op == OP_CDEC;
  endfunction

  // Returns {A:mem,aluwb,lwwb, B:mem,aluwb,lwwb}.
  function automatic logic [5:0] model_byp(input logic [31:0] ex, input logic [31:0] mem,
                                           input logic [31:0] wb);
    logic [5:0] op = ex[31:26];
    logic [2:0] sel [2];
    int  src [2];
    bit  rd_a, rd_b;
    rd_a   = op inside {OP_ALU, OP_LW, OP_SW, OP_CDEC, OP_IJMP};
    rd_b   = op inside {OP_ALU, OP_SW, OP_CDEC, OP_IJMP};
    src[0] = rd_a ? int'(ex[25:21]) : 0;
    src[1] = rd_b ? int'(ex[20:16]) : 0;
    for (int k = 0; k < 2; k++) begin
      sel[k] = 3'b000;
      if (src[k] != 0) begin
        if (alu_class(mem) && writes(mem) == src[k]) sel[k] = 3'b100;
        else if (alu_class(wb) && writes(wb) == src[k]) sel[k] = 3'b010;
        else if (wb[31:26] == OP_LW && int'(wb[20:16]) == src[k]) sel[k] = 3'b001;
      end
    end
    return {sel[0], sel[1]};
  endfunction

  function automatic bit model_lu(input logic [31:0] f, input logic [31:0] e);
    int r = int'(e[20:16]);
    bit fb = f[31:26] inside {OP_ALU, OP_SW, OP_CDEC, OP_IJMP};
    return e[31:26] == OP_LW && r != 0 && (r == int'(f[25:21]) || (fb && r == int'(f[20:16])));
  endfunction

  function automatic logic [31:0] rnd_ir();
    logic [5:0] ops [6] = '{OP_ALU, OP_LW, OP_SW, OP_CDEC, OP_IJMP, OP_NOP};
    return {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d);
    ifid = a; idex = b; exmem = c; memwb = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int fl, sc, fcm;
  logic [5:0] e_byp;
  bit e_lu, e_ij, e_rd, e_st;

  initial begin
    reset = 1'b1;
    drive(NOP, mk(OP_ALU, 3, 3, 4), mk(OP_ALU, 1, 2, 3), NOP);
    ifid2 = NOP; idex2 = NOP; exmem2 = NOP; memwb2 = NOP;
    tick();
    @(negedge clk);
    chk("reset_byp", byp, 0);
    chk("reset_ijmp", {stall, ijmp, redir}, 0);
    tick();
    chk("reset_cnts", {scnt, fcnt}, 0);
    reset = 1'b0;

    // forward both operands from an ALU result in MEM
    @(negedge clk); chk("t1_byp", byp, 6'b100_100);
    tick();
    // MEM result beats LW in WB for the same register
    drive(NOP, mk(OP_ALU, 5, 1, 9), mk(OP_ALU, 1, 2, 5), mk(OP_LW, 1, 5, 0));
    @(negedge clk); chk("t2_byp", byp, 6'b100_000);
    tick();
    // load-use: one stall, then LW forwards from WB after the bubble
    drive(mk(OP_ALU, 2, 6, 7), mk(OP_LW, 1, 6, 0), NOP, NOP);
    @(negedge clk); chk("t3_stall", stall, 1); chk("t3_cnt0", scnt, 0);
    tick(); chk("t3_cnt1", scnt, 1);
    drive(mk(OP_ALU, 2, 6, 7), NOP, mk(OP_LW, 1, 6, 0), NOP);
    @(negedge clk); chk("t3_nostall", stall, 0);
    tick();
    drive(NOP, mk(OP_ALU, 2, 6, 7), NOP, mk(OP_LW, 1, 6, 0));
    @(negedge clk); chk("t3_lwwb", byp, 6'b000_001);
    tick();
    // r0 never forwards or stalls
    drive(mk(OP_ALU, 0, 0, 1), mk(OP_ALU, 0, 0, 2), mk(OP_ALU, 1, 1, 0), mk(OP_LW, 1, 0, 0));
    @(negedge clk); chk("t4_byp", byp, 0); chk("t4_stall", stall, 0);
    tick();
    drive(mk(OP_ALU, 0, 0, 1), mk(OP_LW, 0, 0, 0), mk(OP_CDEC, 1, 0, 0), NOP);
    @(negedge clk); chk("t4_lw0", {byp, stall}, 0);
    tick();
    // IJMP flush overrides a simultaneous load-use
    drive(mk(OP_ALU, 6, 1, 7), mk(OP_LW, 1, 6, 0), mk(OP_IJMP, 0, 0, 0), NOP);
    @(negedge clk);
    chk("t5_c1", {ijmp, redir, stall}, 3'b110); chk("t5_fc0", fcnt, 0);
    tick(); chk("t5_fc1", fcnt, 1); chk("t5_sc", scnt, 1);
    @(negedge clk); chk("t5_c2", {ijmp, redir, stall}, 3'b100);
    tick(); chk("t5_fc_hold", fcnt, 1);
    exmem = NOP;
    @(negedge clk); chk("t5_c3", {ijmp, redir, stall}, 3'b001);
    tick(); chk("t5_sc2", scnt, 2);
    // reset in the middle of a flush
    drive(NOP, NOP, mk(OP_IJMP, 0, 0, 0), NOP);
    tick();
    reset = 1'b1;
    drive(mk(OP_ALU, 6, 1, 7), mk(OP_LW, 1, 6, 0), mk(OP_IJMP, 0, 0, 0), mk(OP_LW, 1, 6, 0));
    @(negedge clk); chk("t6_rst_out", {byp, stall, ijmp, redir}, 0);
    tick();
    reset = 1'b0;
    drive(NOP, NOP, NOP, NOP);
    @(negedge clk);
    chk("t6_idle", {ijmp, redir}, 0); chk("t6_cnts", {scnt, fcnt}, 0);
    tick();
    exmem = mk(OP_IJMP, 0, 0, 0);
    @(negedge clk); chk("t6_new", {ijmp, redir}, 2'b11);
    tick(); exmem = NOP;
    @(negedge clk); chk("t6_hold", {ijmp, redir}, 2'b10);
    tick();
    @(negedge clk); chk("t6_done", ijmp, 0);

    // randomized traffic vs. model; reset applied first so the model starts clean
    reset = 1'b1; tick(); reset = 1'b0;
    fl = 0; sc = 0; fcm = 0;
    for (int i = 0; i < 400; i++) begin
      drive(rnd_ir(), rnd_ir(), rnd_ir(), rnd_ir());
      reset = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      e_ij  = !reset && (fl > 0 || exmem[31:26] == OP_IJMP);
      e_rd  = !reset && fl == 0 && exmem[31:26] == OP_IJMP;
      e_lu  = model_lu(ifid, idex);
      e_st  = !reset && e_lu && !e_ij;
      e_byp = reset ? 6'd0 : model_byp(idex, exmem, memwb);
      chk("rnd_byp", byp, e_byp);
      chk("rnd_ctl", {stall, ijmp, redir}, {e_st, e_ij, e_rd});
      chk("rnd_cnt", {scnt, fcnt}, {16'(sc), 16'(fcm)});
      tick();
      if (reset) begin
        fl = 0; sc = 0; fcm = 0;
      end else begin
        if (e_st) sc = (sc == 65535) ? sc : sc + 1;
        if (e_rd) fcm = (fcm == 65535) ? fcm : fcm + 1;
        if (fl > 0) fl--;
        else if (e_rd) fl = FC - 1;
      end
    end

    // saturation on the 4-bit, single-cycle-flush instance
    reset = 1'b1; drive(NOP, NOP, NOP, NOP); tick(); reset = 1'b0;
    ifid2 = mk(OP_ALU, 6, 1, 7); idex2 = mk(OP_LW, 1, 6, 0); exmem2 = mk(OP_IJMP, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("sat_fc", fcnt2, (i > 15) ? 15 : i);
      chk("sat_ctl", {stall2, ijmp2, redir2}, 3'b011);
      tick();
    end
    exmem2 = NOP;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("sat_sc", scnt2, (i > 15) ? 15 : i);
      chk("sat_st", {stall2, ijmp2}, 2'b10);
      tick();
    end
    chk("sat_fc_end", fcnt2, 15);
    chk("sat_sc_end", scnt2, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
